// File: rtl/int_block_multiplier_pkg.sv
// Shared constants, FSM state encoding and flat-block slice helper for the
// integer block multiplier and its MAC sub-unit.
package int_block_pkg;

    localparam int DIM    = 4;
    localparam int WIDTH  = 32;
    localparam int FLAT_W = DIM * DIM * WIDTH;
    localparam int IDX_W  = $clog2(FLAT_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit offset of element (m,n) in a row-major flattened block.
    function automatic logic [IDX_W-1:0] flat_idx(input logic [1:0] m, input logic [1:0] n);
        return IDX_W'((int'(m) * DIM + int'(n)) * WIDTH);
    endfunction

endpackage

// File: rtl/int_block_multiplier_if.sv
// Strobe/ready/ack block-arithmetic handshake between the matrix-multiply
// controller (master) and a block multiplier (slave).
interface int_block_multiplier_if;
    import int_block_pkg::*;

    logic              A_stb;
    logic              B_stb;
    logic              result_ack;
    logic [FLAT_W-1:0] A;
    logic [FLAT_W-1:0] B;
    logic              result_ready;
    logic [FLAT_W-1:0] result;

    modport master (
        output A_stb, B_stb, result_ack, A, B,
        input  result_ready, result
    );

    modport slave (
        input  A_stb, B_stb, result_ack, A, B,
        output result_ready, result
    );

endinterface

// File: rtl/int_block_multiplier_mac_unit.sv
// Wrap-around multiply-accumulate: sum = (clear ? 0 : acc) + a*b mod 2^WIDTH.
// Latency: combinational, zero cycles.
// Backpressure: none; evaluated every cycle by the caller.
module int_mac_unit
    import int_block_pkg::*;
(
    input  logic             clear,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH-1:0] prod;
    logic [WIDTH-1:0] base;

    // Only the low WIDTH bits matter, so signedness is irrelevant.
    assign prod = a * b;
    assign base = clear ? '0 : acc;
    assign sum  = base + prod;

endmodule

// File: rtl/int_block_multiplier.sv
// Integer 4x4 block multiplier C = A*B, one MAC per cycle, k fastest then n then m.
// Latency: 64 cycles from the accept edge to result_ready.
// Backpressure: result held until result_ack; re-accept needs both strobes seen low in IDLE.
module int_block_multiplier
    import int_block_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    int_block_multiplier_if.slave bus
);

    state_t            state;
    logic              armed;
    logic [FLAT_W-1:0] aq;
    logic [FLAT_W-1:0] bq;
    logic [FLAT_W-1:0] res_q;
    logic              rdy_q;
    logic [WIDTH-1:0]  acc;
    logic [1:0]        m;
    logic [1:0]        n;
    logic [1:0]        k;

    logic [WIDTH-1:0]  a_el;
    logic [WIDTH-1:0]  b_el;
    logic [WIDTH-1:0]  acc_next;
    logic              accept;
    logic              last_step;

    assign accept    = (state == IDLE) && bus.A_stb && bus.B_stb && armed;
    assign last_step = (m == 2'd3) && (n == 2'd3) && (k == 2'd3);

    always_comb begin
        a_el = aq[flat_idx(m, k) +: WIDTH];
        b_el = bq[flat_idx(k, n) +: WIDTH];
    end

    int_mac_unit u_mac (
        .clear (k == 2'd0),
        .acc   (acc),
        .a     (a_el),
        .b     (b_el),
        .sum   (acc_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            armed <= 1'b1;
            aq    <= '0;
            bq    <= '0;
            res_q <= '0;
            rdy_q <= 1'b0;
            acc   <= '0;
            m     <= '0;
            n     <= '0;
            k     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        aq    <= bus.A;
                        bq    <= bus.B;
                        acc   <= '0;
                        m     <= '0;
                        n     <= '0;
                        k     <= '0;
                        armed <= 1'b0;
                        state <= MAC;
                    end else if (!bus.A_stb && !bus.B_stb) begin
                        // Strobes must be seen low once before the next job is taken.
                        armed <= 1'b1;
                    end
                end

                MAC: begin
                    acc <= acc_next;
                    k   <= k + 2'd1;
                    if (k == 2'd3) begin
                        res_q[flat_idx(m, n) +: WIDTH] <= acc_next;
                        n <= n + 2'd1;
                        if (n == 2'd3) begin
                            m <= m + 2'd1;
                        end
                    end
                    if (last_step) begin
                        state <= DONE;
                        rdy_q <= 1'b1;
                    end
                end

                DONE: begin
                    if (bus.result_ack) begin
                        state <= IDLE;
                        rdy_q <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    rdy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.result       = res_q;
    assign bus.result_ready = rdy_q;

endmodule

// File: tb/tb_int_block_multiplier.sv
// Self-checking bench for int_block_multiplier: directed vector table, random
// jobs against a plain matrix-product model, and handshake/reset corner cases.
module tb_int_block_multiplier;
    import int_block_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int_block_multiplier_if bus();

    int_block_multiplier dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int passed = 0;

    typedef struct {
        string        name;
        logic [511:0] a;
        logic [511:0] b;
        logic [511:0] exp;
    } vec_t;

    function automatic logic [31:0] get_el(input logic [511:0] v, input int i);
        logic [511:0] t;
        t = v >> (32 * i);
        return t[31:0];
    endfunction

    function automatic logic [511:0] set_el(input logic [511:0] v, input int i, input logic [31:0] x);
        logic [511:0] mask;
        mask = {480'b0, 32'hFFFF_FFFF} << (32 * i);
        return (v & ~mask) | ({480'b0, x} << (32 * i));
    endfunction

    function automatic logic [511:0] rand_blk();
        logic [511:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) v = set_el(v, i, $urandom());
        return v;
    endfunction

    // Reference: textbook row-by-column product, every sum kept to 32 bits.
    function automatic logic [511:0] ref_mul(input logic [511:0] a, input logic [511:0] b);
        logic [511:0] c;
        logic [31:0]  s;
        c = '0;
        for (int r = 0; r < 4; r++) begin
            for (int col = 0; col < 4; col++) begin
                s = 32'd0;
                for (int j = 0; j < 4; j++) s = s + get_el(a, 4 * r + j) * get_el(b, 4 * j + col);
                c = set_el(c, 4 * r + col, s);
            end
        end
        return c;
    endfunction

    task automatic check_vec(input string name, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Entered at a negedge with the DUT idle and armed; leaves at a negedge.
    task automatic run_job(input string name, input logic [511:0] a, input logic [511:0] b,
                           input logic [511:0] exp, input int a_lead, input int hold,
                           input bit scramble, input bit keep_stb);
        int lat;
        bus.A     = a;
        bus.B     = b;
        bus.A_stb = 1'b1;
        if (a_lead > 0) begin
            repeat (a_lead) @(negedge clk);
            check_int({name, " a_only_ready"}, int'(bus.result_ready), 0);
        end
        bus.B_stb = 1'b1;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        while (!bus.result_ready && lat < 200) begin
            if (scramble) begin
                bus.A = rand_blk();
                bus.B = rand_blk();
            end
            lat++;
            @(negedge clk);
        end
        check_int({name, " latency"}, lat, 64);
        check_vec({name, " result"}, bus.result, exp);
        if (hold > 0) begin
            repeat (hold) begin
                bus.A_stb = 1'($urandom_range(0, 1));
                bus.B_stb = 1'($urandom_range(0, 1));
                bus.A     = rand_blk();
                @(negedge clk);
            end
            check_int({name, " hold_ready"}, int'(bus.result_ready), 1);
            check_vec({name, " hold_result"}, bus.result, exp);
        end
        bus.result_ack = 1'b1;
        bus.A_stb      = keep_stb;
        bus.B_stb      = keep_stb;
        @(negedge clk);
        bus.result_ack = 1'b0;
        check_int({name, " release_ready"}, int'(bus.result_ready), 0);
        if (!keep_stb) @(negedge clk);
    endtask

    initial begin
        vec_t         tbl[3];
        logic [511:0] a;
        logic [511:0] b;
        logic [511:0] e;
        int           high_cnt;

        // Identity x (1..16 row-major) gives B back.
        a = '0; b = '0;
        for (int i = 0; i < 4; i++) a = set_el(a, 5 * i, 32'd1);
        for (int i = 0; i < 16; i++) b = set_el(b, i, 32'(i + 1));
        tbl[0] = '{name: "identity", a: a, b: b, exp: b};
        // All-2 x all-3: each element is 4 * 6 = 24.
        a = '0; b = '0; e = '0;
        for (int i = 0; i < 16; i++) begin
            a = set_el(a, i, 32'd2);
            b = set_el(b, i, 32'd3);
            e = set_el(e, i, 32'h18);
        end
        tbl[1] = '{name: "twos_threes", a: a, b: b, exp: e};
        // 0x80000000 * 2 wraps to zero.
        a = '0; b = '0;
        a = set_el(a, 0, 32'h8000_0000);
        b = set_el(b, 0, 32'd2);
        tbl[2] = '{name: "wrap", a: a, b: b, exp: 512'b0};

        bus.A_stb = 1'b0; bus.B_stb = 1'b0; bus.result_ack = 1'b0;
        bus.A = '0; bus.B = '0;

        repeat (2) @(negedge clk);
        check_int("reset_ready", int'(bus.result_ready), 0);
        check_vec("reset_result", bus.result, 512'b0);
        reset = 1'b1;

        for (int i = 0; i < 3; i++)
            run_job(tbl[i].name, tbl[i].a, tbl[i].b, tbl[i].exp, 0, i, i == 1, 1'b0);

        for (int r = 0; r < 6; r++) begin
            a = rand_blk();
            b = rand_blk();
            run_job("random", a, b, ref_mul(a, b), 0, r % 3, r[0], 1'b0);
        end

        // Only A strobe for 20 cycles, then B: accept on the B edge.
        a = rand_blk(); b = rand_blk();
        run_job("a_lead", a, b, ref_mul(a, b), 20, 0, 1'b0, 1'b0);

        // Strobes held high past the ack must not start a second job.
        a = rand_blk(); b = rand_blk();
        run_job("held_stb", a, b, ref_mul(a, b), 0, 0, 1'b0, 1'b1);
        high_cnt = 0;
        repeat (70) begin
            @(negedge clk);
            if (bus.result_ready) high_cnt++;
        end
        check_int("no_double_accept", high_cnt, 0);
        bus.A_stb = 1'b0; bus.B_stb = 1'b0;
        @(negedge clk);
        a = rand_blk(); b = rand_blk();
        run_job("rearm", a, b, ref_mul(a, b), 0, 0, 1'b0, 1'b0);

        // Reset 30 cycles into MAC drops everything at once.
        bus.A = rand_blk(); bus.B = rand_blk();
        bus.A_stb = 1'b1; bus.B_stb = 1'b1;
        @(posedge clk);
        repeat (30) @(negedge clk);
        reset = 1'b0;
        #1;
        check_int("mid_reset_ready", int'(bus.result_ready), 0);
        check_vec("mid_reset_result", bus.result, 512'b0);
        bus.A_stb = 1'b0; bus.B_stb = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        a = rand_blk(); b = rand_blk();
        run_job("after_reset", a, b, ref_mul(a, b), 0, 0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
